// File: rtl/cluster_count_monitor.sv
// Windowed sum/peak/overflow integrator for the per-clock cluster count, plus a throttle FSM with hysteresis.
// Define CLUSTER_MON_PEAK_EN to build peak tracking; otherwise peak_o is tied to 0.
module cluster_count_monitor #(
  parameter int WINDOW_LOG2     = 12,
  parameter int THROTTLE_THRESH = 4,
  parameter int THROTTLE_HOLD   = 16
) (
  input  logic                     clock4x,
  input  logic                     reset,
  input  logic [10:0]              cnt_i,
  input  logic                     overflow_i,
  input  logic                     clear_i,
  output logic [11+WINDOW_LOG2-1:0] sum_o,
  output logic [10:0]              peak_o,
  output logic [WINDOW_LOG2:0]     ovf_cycles_o,
  output logic                     valid_o,
  output logic                     throttle_o,
  output logic [1:0]               throttle_state
);

  localparam int SUM_W = 11 + WINDOW_LOG2;
  localparam int OVF_W = WINDOW_LOG2 + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_THROTTLE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  localparam logic [7:0] THRESH_LAST = 8'(THROTTLE_THRESH - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(THROTTLE_HOLD - 1);

  // Stage 0: registered sample; smp_vld masks the reset value of cnt_r/ovf_r
  // so the first real sample after reset is sample 0 of a fresh window.
  logic [10:0] cnt_r;
  logic        ovf_r;
  logic        smp_vld;

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
      smp_vld <= 1'b0;
    end else begin
      cnt_r   <= cnt_i;
      ovf_r   <= overflow_i;
      smp_vld <= 1'b1;
    end
  end

  logic [WINDOW_LOG2-1:0] smp_cnt;
  logic [SUM_W-1:0]       acc_sum;
  logic [OVF_W-1:0]       acc_ovf;
  logic [SUM_W-1:0]       sum_next;
  logic [OVF_W-1:0]       ovf_next;
  logic [10:0]            peak_next;
  logic                   win_end;

  always_comb begin
    sum_next = acc_sum + SUM_W'(cnt_r);
    ovf_next = acc_ovf + OVF_W'(ovf_r);
    win_end  = smp_vld && !clear_i && (smp_cnt == '1);
  end

`ifdef CLUSTER_MON_PEAK_EN
  logic [10:0] acc_peak;

  always_comb begin
    peak_next = (cnt_r > acc_peak) ? cnt_r : acc_peak;
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      acc_peak <= '0;
      peak_o   <= '0;
    end else begin
      if (clear_i || win_end) begin
        acc_peak <= '0;
      end else if (smp_vld) begin
        acc_peak <= peak_next;
      end
      if (win_end) begin
        peak_o <= peak_next;
      end
    end
  end
`else
  always_comb begin
    peak_next = '0;
  end

  assign peak_o = peak_next;
`endif

  // Clear takes priority over window end: the sample in cnt_r is dropped
  // and the published results are left untouched.
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      smp_cnt      <= '0;
      acc_sum      <= '0;
      acc_ovf      <= '0;
      sum_o        <= '0;
      ovf_cycles_o <= '0;
      valid_o      <= 1'b0;
    end else begin
      valid_o <= win_end;
      if (clear_i || win_end) begin
        smp_cnt <= '0;
        acc_sum <= '0;
        acc_ovf <= '0;
      end else if (smp_vld) begin
        smp_cnt <= smp_cnt + 1'b1;
        acc_sum <= sum_next;
        acc_ovf <= ovf_next;
      end
      if (win_end) begin
        sum_o        <= sum_next;
        ovf_cycles_o <= ovf_next;
      end
    end
  end

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] run_cnt;
  logic [7:0] run_next;
  logic [7:0] hold_cnt;
  logic [7:0] hold_next;

  // run_cnt counts consecutive overflow samples in IDLE; hold_cnt counts
  // consecutive quiet samples since throttle last saw an overflow.
  always_comb begin
    state_next = state;
    run_next   = run_cnt;
    hold_next  = hold_cnt;
    if (smp_vld) begin
      case (state)
        ST_IDLE: begin
          if (ovf_r) begin
            if (run_cnt == THRESH_LAST) begin
              state_next = ST_THROTTLE;
              run_next   = '0;
            end else begin
              run_next = run_cnt + 8'd1;
            end
          end else begin
            run_next = '0;
          end
        end
        ST_THROTTLE: begin
          if (!ovf_r) begin
            if (HOLD_LAST == 8'd0) begin
              state_next = ST_IDLE;
              hold_next  = '0;
              run_next   = '0;
            end else begin
              state_next = ST_HOLD;
              hold_next  = 8'd1;
            end
          end
        end
        ST_HOLD: begin
          if (ovf_r) begin
            state_next = ST_THROTTLE;
            hold_next  = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_next = ST_IDLE;
            hold_next  = '0;
            run_next   = '0;
          end else begin
            hold_next = hold_cnt + 8'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          run_next   = '0;
          hold_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      run_cnt    <= '0;
      hold_cnt   <= '0;
      throttle_o <= 1'b0;
    end else begin
      state      <= state_next;
      run_cnt    <= run_next;
      hold_cnt   <= hold_next;
      throttle_o <= (state_next != ST_IDLE);
    end
  end

  assign throttle_state = state;

endmodule
